// File: rtl/data_memory_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes,
// response error codes and controller states.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_SIZE     = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory; the requester is the master.
interface data_memory_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_extend.sv
// Load formatter: picks the addressed bytes out of an aligned DATA_W word
// and sign- or zero-extends them to the full data width.
module data_memory_extend
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = 3
) (
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  off,
  input  size_e             size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] rdata
);

  // Works on a 64-bit view so every size slice exists for any DATA_W; the
  // final truncation drops extension bits on a full-width load.
  function automatic logic [63:0] extend(input logic [63:0] v, input size_e sz,
                                         input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (sz)
      SZ_BYTE: extend = sgn ? 64'(b) : {56'd0, v[7:0]};
      SZ_HALF: extend = sgn ? 64'(h) : {48'd0, v[15:0]};
      SZ_WORD: extend = sgn ? 64'(w) : {32'd0, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  logic [DATA_W-1:0] shifted;
  logic [63:0]       wide;
  logic [63:0]       ext;

  always_comb begin
    shifted = word >> {off, 3'b000};
    wide    = 64'(shifted);
    ext     = extend(wide, size, is_signed);
    rdata   = ext[DATA_W-1:0];
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with a one-request-in-flight valid/ready bus,
// optional zero-fill after reset, and aligned little-endian accesses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int INIT_CLEAR = 1
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus
);

  localparam int NB       = DATA_W / 8;
  localparam int OFF_BITS = $clog2(NB);
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_W    = ($clog2(DEPTH) > 0) ? $clog2(DEPTH) : 1;
  localparam int NWORDS   = DEPTH / NB;
  localparam int CNT_W    = ($clog2(NWORDS) > 0) ? $clog2(NWORDS) : 1;

  logic [7:0] mem [DEPTH];

  state_e            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  err_e              rsp_err_q;

  size_e             size;
  logic [3:0]        nbytes;
  logic [ADDR_W:0]   end_addr;
  err_e              req_err;
  logic              accept;
  logic              wr_en;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  blk_base;
  logic [IDX_W-1:0]  clr_base;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] ld_data;

  logic [IDX_W-1:0]  lane_idx  [NB];
  logic [7:0]        lane_data [NB];
  logic              lane_en   [NB];

  assign size     = size_e'(bus.req_size);
  assign nbytes   = size_bytes(size);
  // One extra bit so an address near the top of the space cannot wrap.
  assign end_addr = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes);
  assign accept   = req_ready_q && bus.req_valid;
  assign wr_en    = accept && bus.req_write && (req_err == ERR_OK);
  assign addr_idx = bus.req_addr[IDX_W-1:0];
  assign blk_base = addr_idx & ~IDX_W'(NB - 1);
  assign off      = OFF_W'(addr_idx & IDX_W'(NB - 1));
  assign clr_base = IDX_W'(clr_cnt) << OFF_BITS;

  always_comb begin
    req_err = ERR_OK;
    if (32'(nbytes) > NB)
      req_err = ERR_SIZE;
    else if (end_addr > (ADDR_W+1)'(DEPTH))
      req_err = ERR_RANGE;
    else if ((bus.req_addr & (ADDR_W'(nbytes) - ADDR_W'(1))) != '0)
      req_err = ERR_MISALIGN;
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++)
      rd_word[8*k +: 8] = mem[blk_base | IDX_W'(k)];
  end

  data_memory_extend #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_extend (
    .word      (rd_word),
    .off       (off),
    .size      (size),
    .is_signed (bus.req_signed),
    .rdata     (ld_data)
  );

  // Byte-lane write ports: a clear beat fills one aligned word with zeros,
  // a store touches only the first 2^size lanes starting at the address.
  always_comb begin
    for (int k = 0; k < NB; k++) begin
      lane_idx[k]  = '0;
      lane_data[k] = '0;
      lane_en[k]   = 1'b0;
      if (state == ST_CLEAR) begin
        lane_idx[k] = clr_base | IDX_W'(k);
        lane_en[k]  = 1'b1;
      end else if (wr_en && (k < int'(nbytes))) begin
        lane_idx[k]  = addr_idx + IDX_W'(k);
        lane_data[k] = bus.req_wdata[8*k +: 8];
        lane_en[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++)
      if (lane_en[k])
        mem[lane_idx[k]] <= lane_data[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt     <= '0;
      req_ready_q <= (INIT_CLEAR == 0);
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CNT_W'(NWORDS - 1)) begin
            clr_cnt     <= '0;
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= req_err;
            rsp_rdata_q <= (!bus.req_write && req_err == ERR_OK) ? ld_data : '0;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH, default 128: byte capacity; power of two, at least DATA_W/8.
REQ-002 Parameter DATA_W, default 64: data width in bits; 8, 16, 32 or 64.
REQ-003 Parameter ADDR_W, default 64: byte-address width.
REQ-004 Parameter INIT_CLEAR, default 1: zero the whole array after reset.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port req_valid, input, 1: request present.
REQ-008 Port req_ready, output, 1: request accepted on an edge where req_valid and req_ready are both 1.
REQ-009 Port req_write, input, 1: 1 = store, 0 = load.
REQ-010 Port req_size, input, 2: access size; 0 = byte, 1 = half, 2 = word, 3 = dword; sizes wider than DATA_W are illegal.
REQ-011 Port req_signed, input, 1: load sign-extends when 1 and zero-extends when 0.
REQ-012 Port req_addr, input, ADDR_W: byte address.
REQ-013 Port req_wdata, input, DATA_W: store data; only the low size-bytes are used.
REQ-014 Port rsp_valid, output, 1: response present.
REQ-015 Port rsp_ready, input, 1: response consumed on an edge where rsp_valid and rsp_ready are both 1.
REQ-016 Port rsp_rdata, output, DATA_W: load result; 0 for stores and errors.
REQ-017 Port rsp_err, output, 2: 0 = ok, 1 = misaligned, 2 = out of range, 3 = illegal size.

Function
REQ-018 FSM states SHALL be CLEAR, IDLE and RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-019 CLEAR SHALL write zero to DATA_W/8 bytes per cycle, counting up from 0; after DEPTH/(DATA_W/8) cycles it moves to IDLE (16 cycles at the defaults).
REQ-020 On acceptance in IDLE the block SHALL capture the request, perform the store or load at that same edge, and enter RESP, giving a latency of 1 cycle.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is 1; on that edge the state returns to IDLE.
REQ-022 Peak throughput SHALL be one request per 2 cycles; no request is accepted while in RESP.
REQ-023 Byte order SHALL be little-endian: the byte at req_addr maps to bits [7:0], and the byte at req_addr+k maps to bits [8k+7:8k].
REQ-024 Error priority SHALL be illegal size, then out of range (req_addr + 2^size > DEPTH, computed without overflow), then misaligned (req_addr mod 2^size != 0).
REQ-025 An errored store SHALL leave the array unchanged; an errored load SHALL return rsp_rdata = 0.
REQ-026 A store SHALL modify exactly 2^size bytes; all other bytes are preserved.
REQ-027 req_signed SHALL be ignored for stores and for a full-DATA_W load.
REQ-028 Back-to-back store then load to the same address SHALL return the newly stored data.

Reset
REQ-029 Reset assertion SHALL immediately force rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0, and discard any pending response.
REQ-030 During reset the state SHALL be CLEAR when INIT_CLEAR = 1 and IDLE when INIT_CLEAR = 0, with req_ready = 0 or 1 respectively and the clear counter = 0.
REQ-031 Array contents SHALL NOT be reset asynchronously; with INIT_CLEAR = 0 they are undefined after reset.
REQ-032 Reset asserted in any state, including mid-CLEAR, SHALL restart the sequence from the start.

Structure
REQ-033 Package data_memory_pkg SHALL hold the size codes, error codes and FSM state encoding.
REQ-034 Sub-module data_memory_extend (combinational: byte select, sign/zero extension) SHALL produce the load result.
REQ-035 The array SHALL be a byte array of DEPTH entries written only in the clocked process.

Verification
REQ-036 Reset released with defaults -> req_ready = 0 for 16 cycles, then 1; a dword load at 0 returns 0.
REQ-037 Store dword 0x8877665544332211 at 8, then load byte at 15 with req_signed = 1 -> rsp_rdata = 0xFFFFFFFFFFFFFF88, rsp_err = 0.
REQ-038 Store half 0xBEEF at 20, then load word at 20 -> 0x0000BEEF; the other bytes of that word are unchanged.
REQ-039 Load word at 6 -> rsp_err = 1; store dword at 124 -> rsp_err = 2, with the array unchanged (checked by readback).
REQ-040 Hold rsp_ready = 0 for 5 cycles -> response stable and req_ready = 0 throughout; then rsp_ready = 1 -> IDLE next edge.
REQ-041 Assert reset while in RESP -> rsp_valid drops with no clock edge; the CLEAR sequence reruns.
